// File: rtl/max7219_display.sv
// max7219_display: drives a daisy chain of MAX7219 8-digit 7-segment drivers.
// Each chip shows 4 frame bytes as 8 hex digits. After a one-time INIT the
// block refreshes digit registers 8..1 forever.
//
// Handshake/timing contract on the serial side: cs falls, then 16*NUM_CASCADES
// bits are shifted MSB first; dout only changes in the cycle spi_clk goes (or
// stays) low and is held for a full CLK_DIV low phase before each rising edge;
// CLK_DIV cycles after the last falling edge cs rises, and cs then stays high
// for 2*CLK_DIV cycles before the next transaction.
module max7219_display #(
    parameter int NUM_CASCADES = 2,
    parameter int INTENSITY    = 1,
    parameter int CLK_DIV      = 4
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic [7:0]  frame [4*NUM_CASCADES],
    output logic        spi_clk,
    output logic        dout,
    output logic        cs,
    output logic        stop,
    output logic [10:1] pin
);

    localparam int SW = 16 * NUM_CASCADES;
    localparam int CW = $clog2(2 * CLK_DIV);
    localparam int BW = $clog2(SW);

    localparam logic [CW-1:0] GAP_LAST   = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0] PHASE_LAST = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(SW - 1);
    localparam logic [3:0]    INT4       = 4'(INTENSITY);

    // GAP: cs high between words; SHIFT: clocking bits; TAIL: clock idle before cs rises
    typedef enum logic [1:0] {
        ST_GAP   = 2'd0,
        ST_SHIFT = 2'd1,
        ST_TAIL  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [CW-1:0]   cnt;
    logic            sclk;
    logic [SW-1:0]   shreg;
    logic [BW-1:0]   bit_cnt;
    logic            init_done;
    logic [2:0]      init_step;
    logic [3:0]      digit;
    logic            stop_q;

    logic [3:0]      cur_addr;
    logic [7:0]      init_data;
    logic [1:0]      digit_j;
    logic [7:0]      sel_byte;
    logic [7:0]      chip_data;
    logic [SW-1:0]   load_word;

    logic gap_end;
    logic phase_end;
    logic last_bit;

    assign gap_end   = (cnt == GAP_LAST);
    assign phase_end = (cnt == PHASE_LAST);
    assign last_bit  = (bit_cnt == BIT_LAST);

    // Digit registers 8,7 show byte 0 of a chip, 6,5 byte 1, and so on.
    assign digit_j = 2'((4'd8 - digit) >> 1);

    // Segment pattern {DP,A,B,C,D,E,F,G} for one hex nibble, DP always off.
    function automatic logic [7:0] hex_seg(input logic [3:0] n);
        case (n)
            4'h0: hex_seg = 8'h7E;
            4'h1: hex_seg = 8'h30;
            4'h2: hex_seg = 8'h6D;
            4'h3: hex_seg = 8'h79;
            4'h4: hex_seg = 8'h33;
            4'h5: hex_seg = 8'h5B;
            4'h6: hex_seg = 8'h5F;
            4'h7: hex_seg = 8'h70;
            4'h8: hex_seg = 8'h7F;
            4'h9: hex_seg = 8'h7B;
            4'hA: hex_seg = 8'h77;
            4'hB: hex_seg = 8'h1F;
            4'hC: hex_seg = 8'h4E;
            4'hD: hex_seg = 8'h3D;
            4'hE: hex_seg = 8'h4F;
            default: hex_seg = 8'h47;
        endcase
    endfunction

    // Register address and INIT data for the transaction about to be (or being) sent.
    always_comb begin
        cur_addr  = digit;
        init_data = 8'h00;
        if (!init_done) begin
            case (init_step)
                3'd0:    begin cur_addr = 4'hF; init_data = 8'h00; end
                3'd1:    begin cur_addr = 4'hC; init_data = 8'h01; end
                3'd2:    begin cur_addr = 4'h9; init_data = 8'h00; end
                3'd3:    begin cur_addr = 4'hB; init_data = 8'h07; end
                default: begin cur_addr = 4'hA; init_data = {4'h0, INT4}; end
            endcase
        end
    end

    // Full chain word: farthest chip in the top 16 bits so it is shifted out first.
    always_comb begin
        load_word = '0;
        sel_byte  = 8'h00;
        chip_data = 8'h00;
        for (int k = 0; k < NUM_CASCADES; k++) begin
            sel_byte  = frame[4*k + int'(digit_j)];
            chip_data = init_done ? hex_seg(digit[0] ? sel_byte[3:0] : sel_byte[7:4])
                                  : init_data;
            load_word[16*k +: 16] = {4'h0, cur_addr, chip_data};
        end
    end

    // State register.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) state <= ST_GAP;
        else        state <= state_n;
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        case (state)
            ST_GAP:   if (gap_end) state_n = ST_SHIFT;
            ST_SHIFT: if (phase_end && sclk && last_bit) state_n = ST_TAIL;
            ST_TAIL:  if (phase_end) state_n = ST_GAP;
            default:  state_n = ST_GAP;
        endcase
    end

    // Counters, shift register and INIT/refresh sequencing.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            sclk      <= 1'b0;
            shreg     <= '0;
            bit_cnt   <= '0;
            init_done <= 1'b0;
            init_step <= 3'd0;
            digit     <= 4'd8;
            stop_q    <= 1'b0;
        end else begin
            stop_q <= 1'b0;
            case (state)
                ST_GAP: begin
                    if (gap_end) begin
                        // cs falls here: the frame is sampled into the word now
                        cnt     <= '0;
                        sclk    <= 1'b0;
                        bit_cnt <= '0;
                        shreg   <= load_word;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (phase_end) begin
                        cnt <= '0;
                        if (!sclk) begin
                            sclk <= 1'b1;
                        end else begin
                            sclk <= 1'b0;
                            if (!last_bit) begin
                                bit_cnt <= bit_cnt + 1'b1;
                                shreg   <= {shreg[SW-2:0], 1'b0};
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_TAIL: begin
                    if (phase_end) begin
                        cnt <= '0;
                        if (!init_done) begin
                            if (init_step == 3'd4) begin
                                init_done <= 1'b1;
                                digit     <= 4'd8;
                            end else begin
                                init_step <= init_step + 3'd1;
                            end
                        end else if (digit == 4'd1) begin
                            digit  <= 4'd8;
                            stop_q <= 1'b1;
                        end else begin
                            digit <= digit - 4'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    // Outputs and debug pins, all decoded from registered state.
    always_comb begin
        cs      = (state == ST_GAP);
        spi_clk = sclk;
        dout    = (state == ST_GAP) ? 1'b0 : shreg[SW-1];
        stop    = stop_q;
        pin     = {2'b00, cur_addr, init_done, cs, dout, spi_clk};
    end

endmodule

// File: tb/tb_max7219_display.sv
// Bench for max7219_display: an SPI monitor rebuilds each chain word at cs rise
// and checks it, together with stop and timing, against an expected queue.
module tb_max7219_display;

    localparam int N  = 2;
    localparam int CD = 4;
    localparam int TXN_CYC = 300;

    localparam logic [7:0] HEX [16] = '{8'h7E, 8'h30, 8'h6D, 8'h79, 8'h33, 8'h5B, 8'h5F, 8'h70,
                                       8'h7F, 8'h7B, 8'h77, 8'h1F, 8'h4E, 8'h3D, 8'h4F, 8'h47};

    logic        sysclk;
    logic        reset;
    logic [7:0]  frame [4*N];
    logic        spi_clk, dout, cs, stop;
    logic [10:1] pin;
    logic        spi2, dout2, cs2, stop2;
    logic [10:1] pin2;

    max7219_display #(.NUM_CASCADES(N), .INTENSITY(1), .CLK_DIV(CD)) dut (
        .sysclk (sysclk),
        .reset  (reset),
        .frame  (frame),
        .spi_clk(spi_clk),
        .dout   (dout),
        .cs     (cs),
        .stop   (stop),
        .pin    (pin)
    );

    max7219_display #(.NUM_CASCADES(N), .INTENSITY(15), .CLK_DIV(2)) dut2 (
        .sysclk (sysclk),
        .reset  (reset),
        .frame  (frame),
        .spi_clk(spi2),
        .dout   (dout2),
        .cs     (cs2),
        .stop   (stop2),
        .pin    (pin2)
    );

    // clock
    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    typedef struct {
        int          digit;
        logic        stop;
        logic [31:0] word;
    } vec_t;

    vec_t        ref_tab [8];
    logic [31:0] init_tab [5];
    logic [7:0]  f1 [8];
    logic [7:0]  f2 [8];
    logic [32:0] exp_q [$];

    int tests = 0;
    int fails = 0;

    // monitor state
    int          cyc = 0;
    int          cs_fall_cnt = 0;
    int          pop_cnt = 0;
    int          words_done = 0;
    int          stop_cnt = 0;
    int          stray_stop = 0;
    int          bits = 0;
    int          last_rise_cyc = 0;
    int          last_fall_cyc = 0;
    int          last_dout_chg = 0;
    int          cs_rise_cyc = 0;
    bit          cs_rise_ok = 0;
    bit          rise_valid = 0;
    bit          in_txn = 0;
    bit          tim_ok = 1;
    bit          pin_ok = 1;
    logic [3:0]  pin_addr = 4'h0;
    logic [31:0] sh = '0;
    logic        prev_cs = 1'b1;
    logic        prev_sclk = 1'b0;
    logic        prev_dout = 1'b0;

    // second instance monitor state
    int          n2 = 0;
    int          stop2_init = 0;
    bit          pin2_ok = 1;
    logic [31:0] sh2 = '0;
    logic [31:0] w5 = '0;
    logic        prev_cs2 = 1'b1;
    logic        prev_spi2 = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [7:0] f [8], input int d);
        logic [15:0] w [2];
        int j;
        logic [7:0] b;
        j = (8 - d) / 2;
        for (int c = 0; c < 2; c++) begin
            b = f[4*c + j];
            w[c] = {4'h0, 4'(d), HEX[(d % 2 == 0) ? b[7:4] : b[3:0]]};
        end
        return {w[1], w[0]};
    endfunction

    task automatic run_monitor();
        logic [32:0] e;
        bit rose;
        forever begin
            @(negedge sysclk);
            cyc++;
            if (!reset) begin
                in_txn = 0; words_done = 0; cs_rise_ok = 0;
                prev_cs = cs; prev_sclk = spi_clk; prev_dout = dout;
                continue;
            end
            rose = 0;
            if (pin[3:1] !== {cs, dout, spi_clk} || pin[10:9] !== 2'b00) pin_ok = 0;
            if (dout !== prev_dout) begin
                last_dout_chg = cyc;
                if (spi_clk) tim_ok = 0;
            end
            if (!cs && prev_cs) begin
                cs_fall_cnt++;
                in_txn = 1; bits = 0; sh = '0; tim_ok = 1; pin_ok = 1; rise_valid = 0;
                if (cs_rise_ok && (cyc - cs_rise_cyc) < 2*CD) tim_ok = 0;
                last_fall_cyc = cyc;
            end
            if (in_txn && spi_clk && !prev_sclk) begin
                if (cyc - last_dout_chg < CD) tim_ok = 0;
                if (rise_valid && (cyc - last_rise_cyc) != 2*CD) tim_ok = 0;
                if (cyc - last_fall_cyc != CD) tim_ok = 0;
                rise_valid = 1; last_rise_cyc = cyc;
                sh = {sh[30:0], dout}; bits++;
                pin_addr = pin[8:5];
                if (pin[4] !== (words_done >= 5)) pin_ok = 0;
            end
            if (in_txn && !spi_clk && prev_sclk) begin
                if (cyc - last_rise_cyc != CD) tim_ok = 0;
                last_fall_cyc = cyc;
            end
            if (cs && !prev_cs && in_txn) begin
                rose = 1;
                in_txn = 0; cs_rise_cyc = cyc; cs_rise_ok = 1;
                if (spi_clk || (cyc - last_fall_cyc) != CD) tim_ok = 0;
                if (stop) stop_cnt++;
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL word: got %h with no expected word queued", sh);
                end else begin
                    e = exp_q.pop_front();
                    check("word_stop", {stop, sh}, e);
                    check("bit_count", bits, 32);
                    check("timing", tim_ok, 1);
                    check("pin", {pin_ok, pin_addr}, {1'b1, e[11:8]});
                end
                words_done++;
                pop_cnt++;
            end
            if (stop && !rose) stray_stop++;
            prev_cs = cs; prev_sclk = spi_clk; prev_dout = dout;
        end
    endtask

    task automatic run_mon2();
        forever begin
            @(negedge sysclk);
            if (!reset) begin
                n2 = 0; prev_cs2 = cs2; prev_spi2 = spi2;
                continue;
            end
            if (pin2[3:1] !== {cs2, dout2, spi2} || pin2[10:9] !== 2'b00 || pin2[8:5] == 4'h0)
                pin2_ok = 0;
            if (!cs2 && prev_cs2) sh2 = '0;
            if (!cs2 && spi2 && !prev_spi2) sh2 = {sh2[30:0], dout2};
            if (cs2 && !prev_cs2) begin
                n2++;
                if (n2 == 5) w5 = sh2;
                if (stop2 && n2 <= 5) stop2_init++;
            end
            prev_cs2 = cs2; prev_spi2 = spi2;
        end
    endtask

    task automatic wait_falls(input int n, input int budget);
        int k = 0;
        while (cs_fall_cnt < n && k < budget) begin
            @(negedge sysclk);
            k++;
        end
        check("wait_cs_fall", cs_fall_cnt >= n, 1);
    endtask

    task automatic wait_pops(input int n, input int budget);
        int k = 0;
        while (pop_cnt < n && k < budget) begin
            @(negedge sysclk);
            k++;
        end
        check("wait_words", pop_cnt >= n, 1);
    endtask

    task automatic push_init();
        for (int i = 0; i < 5; i++) exp_q.push_back({1'b0, init_tab[i]});
    endtask

    initial begin
        f1 = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        f2 = f1;
        f2[0] = 8'hA5;
        init_tab = '{32'h0F000F00, 32'h0C010C01, 32'h09000900, 32'h0B070B07, 32'h0A010A01};
        ref_tab[0] = '{8, 1'b0, 32'h087B0830};
        ref_tab[1] = '{7, 1'b0, 32'h0777076D};
        ref_tab[2] = '{6, 1'b0, 32'h061F0679};
        ref_tab[3] = '{5, 1'b0, 32'h054E0533};
        ref_tab[4] = '{4, 1'b0, 32'h043D045B};
        ref_tab[5] = '{3, 1'b0, 32'h034F035F};
        ref_tab[6] = '{2, 1'b0, 32'h02470270};
        ref_tab[7] = '{1, 1'b1, 32'h017E017F};

        reset = 1'b0;
        frame = f1;
        fork
            run_monitor();
            run_mon2();
        join_none

        // reset state
        repeat (3) @(posedge sysclk);
        #1;
        check("reset_outs", {cs, spi_clk, dout, stop}, 4'b1000);
        check("reset_pin", pin, {2'b00, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0});

        // INIT, pass 1 from the table, pass 2 with frame[0] changed during digit 8, pass 3
        push_init();
        for (int i = 0; i < 8; i++) exp_q.push_back({ref_tab[i].stop, ref_tab[i].word});
        exp_q.push_back({1'b0, model_word(f1, 8)});
        for (int d = 7; d >= 1; d--) exp_q.push_back({d == 1, model_word(f2, d)});
        for (int d = 8; d >= 1; d--) exp_q.push_back({d == 1, model_word(f2, d)});

        @(negedge sysclk);
        reset = 1'b1;

        wait_falls(14, 14 * TXN_CYC);
        repeat (40) @(negedge sysclk);
        frame[0] = 8'hA5;

        wait_pops(29, 20 * TXN_CYC);
        check("stop_count", stop_cnt, 3);
        check("intensity15_init", {n2 >= 5, w5, pin2[4]}, {1'b1, 32'h0A0F0A0F, 1'b1});
        check("dut2_no_stop_in_init", stop2_init, 0);
        check("dut2_pin", pin2_ok, 1);

        // reset in the middle of a shift aborts it and restarts INIT
        wait_falls(30, 2 * TXN_CYC);
        repeat (50) @(posedge sysclk);
        #2;
        reset = 1'b0;
        #1;
        check("midshift_reset_outs", {cs, spi_clk, dout, stop}, 4'b1000);
        check("midshift_reset_pin", pin, {2'b00, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0});
        push_init();
        repeat (5) @(negedge sysclk);
        reset = 1'b1;

        wait_pops(34, 7 * TXN_CYC);
        check("init_done_pin", pin[4], 1'b1);
        check("queue_empty", exp_q.size(), 0);
        check("stray_stop", stray_stop, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
